// File: rtl/datapath_core_pkg.sv
// rtl/datapath_core_pkg.sv - opcodes, state encodings and instruction field widths
package datapath_core_pkg;

    localparam int OP_W     = 3;
    localparam int DEF_N    = 16;
    localparam int DEF_REGS = 16;
    localparam int DEF_SEL  = 4;

    localparam logic [OP_W-1:0] OP_PASS = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
    localparam logic [OP_W-1:0] OP_AND  = 3'b011;
    localparam logic [OP_W-1:0] OP_OR   = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL1 = 3'b110;
    localparam logic [OP_W-1:0] OP_DIV  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

endpackage

// File: rtl/datapath_core_if.sv
// rtl/datapath_core_if.sv - micro-instruction valid/ready channel
interface datapath_core_if #(
    parameter int P_SEL = 4
);
    import datapath_core_pkg::*;

    logic             instr_valid;
    logic             instr_ready;
    logic [OP_W-1:0]  instr_op;
    logic [P_SEL-1:0] instr_ra;
    logic [P_SEL-1:0] instr_rb;
    logic [P_SEL-1:0] instr_rd;
    logic             instr_we;

    modport master (
        output instr_valid, instr_op, instr_ra, instr_rb, instr_rd, instr_we,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_ra, instr_rb, instr_rd, instr_we,
        output instr_ready
    );

endinterface

// File: rtl/datapath_core_div_iter.sv
// rtl/datapath_core_div_iter.sv - iterative restoring unsigned divider, one bit per cycle
module datapath_core_div_iter #(
    parameter int P_N = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [P_N-1:0] i_a,
    input  logic [P_N-1:0] i_b,
    output logic           o_busy,
    output logic           o_done,
    output logic [P_N-1:0] o_quotient,
    output logic [P_N-1:0] o_remainder,
    output logic           o_div_by_zero
);
    localparam int CW = $clog2(P_N + 1);

    logic           r_busy;
    logic           r_dbz;
    logic [P_N-1:0] r_q;
    logic [P_N-1:0] r_rem;
    logic [P_N-1:0] r_b;
    logic [CW-1:0]  r_cnt;

    logic [P_N:0]   w_trial;
    logic [P_N:0]   w_diff;
    logic           w_fit;
    logic [P_N-1:0] w_q_next;
    logic [P_N-1:0] w_rem_next;

    // r_q starts as the dividend; its top bit shifts into the partial remainder while
    // quotient bits enter at the bottom. On divide-by-zero r_q still holds A.
    always_comb begin
        w_trial    = {r_rem, r_q[P_N-1]};
        w_diff     = w_trial - {1'b0, r_b};
        w_fit      = (w_trial >= {1'b0, r_b});
        w_q_next   = {r_q[P_N-2:0], w_fit};
        w_rem_next = w_fit ? w_diff[P_N-1:0] : w_trial[P_N-1:0];
        if (r_dbz) begin
            w_q_next   = '1;
            w_rem_next = r_q;
        end
    end

    // Done marks the edge on which the final step lands, so the outputs carry the
    // completed results in that same cycle.
    assign o_done        = r_busy & (r_dbz | (r_cnt == CW'(1)));
    assign o_busy        = r_busy;
    assign o_quotient    = w_q_next;
    assign o_remainder   = w_rem_next;
    assign o_div_by_zero = r_dbz;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_dbz  <= 1'b0;
            r_q    <= '0;
            r_rem  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_dbz  <= (i_b == '0);
            r_q    <= i_a;
            r_rem  <= '0;
            r_b    <= i_b;
            r_cnt  <= CW'(P_N);
        end else if (r_busy) begin
            r_q   <= w_q_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt - CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/datapath_core.sv
// rtl/datapath_core.sv - register file, single-cycle ALU, flags and DIV sequencing
module datapath_core
    import datapath_core_pkg::*;
#(
    parameter int P_N    = DEF_N,
    parameter int P_REGS = DEF_REGS,
    parameter int P_SEL  = DEF_SEL
) (
    input  logic             i_clk,
    input  logic             i_rst,
    datapath_core_if.slave   instr,
    output logic             o_done,
    output logic             o_mayor,
    output logic             o_zero,
    output logic             o_paridad,
    output logic             o_div_err,
    output logic [P_N-1:0]   o_remainder,
    input  logic [P_SEL-1:0] i_obs_sel,
    output logic [P_N-1:0]   o_obs_data
);
    logic [P_N-1:0]   r_regs [P_REGS];
    state_t           r_state;
    logic             r_done;
    logic             r_mayor;
    logic             r_zero;
    logic             r_paridad;
    logic             r_div_err;
    logic [P_N-1:0]   r_remainder;
    logic [P_SEL-1:0] r_lat_rd;
    logic             r_lat_we;
    logic             r_lat_mayor;

    logic             w_ready;
    logic             w_accept;
    logic             w_div_start;
    logic [P_N-1:0]   w_a;
    logic [P_N-1:0]   w_b;
    logic [P_N-1:0]   w_alu;
    logic             w_div_busy;
    logic             w_div_done;
    logic [P_N-1:0]   w_div_q;
    logic [P_N-1:0]   w_div_rem;
    logic             w_div_dbz;

    assign w_ready           = (r_state == ST_IDLE) & ~w_div_busy & ~i_rst;
    assign instr.instr_ready = w_ready;
    assign w_accept          = instr.instr_valid & w_ready;
    assign w_div_start       = w_accept & (instr.instr_op == OP_DIV);

    assign w_a        = r_regs[instr.instr_ra];
    assign w_b        = r_regs[instr.instr_rb];
    assign o_obs_data = r_regs[i_obs_sel];

    always_comb begin
        w_alu = w_a;
        case (instr.instr_op)
            OP_PASS: w_alu = w_a;
            OP_ADD:  w_alu = w_a + w_b;
            OP_SUB:  w_alu = w_a - w_b;
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_XOR:  w_alu = w_a ^ w_b;
            OP_SHL1: w_alu = {w_a[P_N-2:0], 1'b0};
            default: w_alu = w_a;
        endcase
    end

    datapath_core_div_iter #(
        .P_N (P_N)
    ) u_div (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (w_div_start),
        .i_a           (w_a),
        .i_b           (w_b),
        .o_busy        (w_div_busy),
        .o_done        (w_div_done),
        .o_quotient    (w_div_q),
        .o_remainder   (w_div_rem),
        .o_div_by_zero (w_div_dbz)
    );

    // The A>B compare for a DIV is taken at accept and held until it retires.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < P_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_mayor     <= 1'b0;
            r_zero      <= 1'b0;
            r_paridad   <= 1'b0;
            r_div_err   <= 1'b0;
            r_remainder <= '0;
            r_lat_rd    <= '0;
            r_lat_we    <= 1'b0;
            r_lat_mayor <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (instr.instr_op == OP_DIV) begin
                            r_state     <= ST_DIV;
                            r_lat_rd    <= instr.instr_rd;
                            r_lat_we    <= instr.instr_we;
                            r_lat_mayor <= (w_a > w_b);
                        end else begin
                            if (instr.instr_we) begin
                                r_regs[instr.instr_rd] <= w_alu;
                            end
                            r_done    <= 1'b1;
                            r_mayor   <= (w_a > w_b);
                            r_zero    <= (w_alu == '0);
                            r_paridad <= ^w_alu;
                            r_div_err <= 1'b0;
                        end
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        if (r_lat_we) begin
                            r_regs[r_lat_rd] <= w_div_q;
                        end
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b1;
                        r_mayor     <= r_lat_mayor;
                        r_zero      <= (w_div_q == '0);
                        r_paridad   <= ^w_div_q;
                        r_div_err   <= w_div_dbz;
                        r_remainder <= w_div_rem;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_done      = r_done;
    assign o_mayor     = r_mayor;
    assign o_zero      = r_zero;
    assign o_paridad   = r_paridad;
    assign o_div_err   = r_div_err;
    assign o_remainder = r_remainder;

endmodule

// File: tb/tb_datapath_core.sv
// tb/tb_datapath_core.sv - directed self-checking bench for datapath_core
module tb_datapath_core;
    import datapath_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        done, mayor, zero, paridad, div_err;
    logic [15:0] remainder;
    logic [15:0] obs_data;
    logic [3:0]  obs_sel;

    int n_vec = 0;
    int n_err = 0;

    datapath_core_if #(.P_SEL(4)) bus ();

    datapath_core #(
        .P_N    (16),
        .P_REGS (16),
        .P_SEL  (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .instr       (bus),
        .o_done      (done),
        .o_mayor     (mayor),
        .o_zero      (zero),
        .o_paridad   (paridad),
        .o_div_err   (div_err),
        .o_remainder (remainder),
        .i_obs_sel   (obs_sel),
        .o_obs_data  (obs_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_is(input string tag, input logic [3:0] idx, input logic [15:0] exp);
        obs_sel = idx;
        #1;
        chk(tag, {16'h0, obs_data}, {16'h0, exp});
    endtask

    task automatic op1(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rd, input logic we);
        @(negedge clk);
        bus.instr_op    = op;
        bus.instr_ra    = ra;
        bus.instr_rb    = rb;
        bus.instr_rd    = rd;
        bus.instr_we    = we;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic do_div(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
                          output int edges, output int lows);
        @(negedge clk);
        bus.instr_op    = OP_DIV;
        bus.instr_ra    = ra;
        bus.instr_rb    = rb;
        bus.instr_rd    = rd;
        bus.instr_we    = 1'b1;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        edges = 1;
        lows  = 0;
        while (!done && edges < 40) begin
            if (!bus.instr_ready) lows++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, l, spur;
        rst             = 1'b1;
        obs_sel         = '0;
        bus.instr_valid = 1'b0;
        bus.instr_op    = OP_PASS;
        bus.instr_ra    = '0;
        bus.instr_rb    = '0;
        bus.instr_rd    = '0;
        bus.instr_we    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("ready_in_reset", {31'h0, bus.instr_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) reg_is("reset_reg", 4'(i), 16'h0000);
        chk("reset_ready", {31'h0, bus.instr_ready}, 32'h1);
        chk("reset_flags", {27'h0, done, mayor, zero, paridad, div_err}, 32'h0);
        chk("reset_rem", {16'h0, remainder}, 32'h0);

        // r15 = 0/0 -> all ones; the only way to seed a nonzero value
        do_div(4'd0, 4'd0, 4'd15, e, l);
        chk("div0_edges", e, 2);
        chk("div0_err", {31'h0, div_err}, 32'h1);
        reg_is("r15_ones", 4'd15, 16'hFFFF);

        op1(OP_SUB, 4'd0, 4'd15, 4'd3, 1'b1);
        chk("sub_done", {31'h0, done}, 32'h1);
        reg_is("r3_one", 4'd3, 16'h0001);

        // back-to-back SHL1 on the same register: each read sees the prior write
        op1(OP_SHL1, 4'd3, 4'd0, 4'd14, 1'b1);
        for (int k = 0; k < 14; k++) op1(OP_SHL1, 4'd14, 4'd0, 4'd14, 1'b1);
        reg_is("r14_8000", 4'd14, 16'h8000);

        op1(OP_SUB, 4'd14, 4'd3, 4'd2, 1'b1);
        reg_is("r2_7fff", 4'd2, 16'h7FFF);

        op1(OP_ADD, 4'd2, 4'd3, 4'd4, 1'b1);
        chk("add_flags", {28'h0, done, zero, paridad, mayor}, 32'b1011);
        reg_is("r4_add", 4'd4, 16'h8000);

        op1(OP_SUB, 4'd3, 4'd2, 4'd5, 1'b1);
        chk("sub_flags", {29'h0, zero, paridad, mayor}, 32'b000);
        reg_is("r5_wrap", 4'd5, 16'h8002);

        op1(OP_SHL1, 4'd3,  4'd0,  4'd8,  1'b1);
        op1(OP_SHL1, 4'd8,  4'd0,  4'd8,  1'b1);
        op1(OP_SHL1, 4'd8,  4'd0,  4'd9,  1'b1);
        op1(OP_SUB,  4'd9,  4'd3,  4'd7,  1'b1);
        op1(OP_SHL1, 4'd9,  4'd0,  4'd10, 1'b1);
        op1(OP_SHL1, 4'd10, 4'd0,  4'd10, 1'b1);
        op1(OP_SHL1, 4'd10, 4'd0,  4'd11, 1'b1);
        op1(OP_OR,   4'd11, 4'd10, 4'd12, 1'b1);
        op1(OP_OR,   4'd12, 4'd8,  4'd12, 1'b1);
        reg_is("r7_seven", 4'd7, 16'd7);
        reg_is("r12_100", 4'd12, 16'd100);

        op1(OP_AND, 4'd12, 4'd7, 4'd13, 1'b1);
        reg_is("and", 4'd13, 16'h0004);
        op1(OP_XOR, 4'd12, 4'd7, 4'd13, 1'b1);
        reg_is("xor", 4'd13, 16'h0063);
        op1(OP_PASS, 4'd12, 4'd0, 4'd13, 1'b1);
        chk("pass_mayor", {31'h0, mayor}, 32'h1);
        reg_is("pass", 4'd13, 16'h0064);

        do_div(4'd12, 4'd7, 4'd6, e, l);
        chk("div_edges", e, 17);
        chk("div_ready_low", l, 16);
        chk("div_flags", {28'h0, div_err, zero, paridad, mayor}, 32'b0011);
        chk("div_rem", {16'h0, remainder}, 32'd2);
        reg_is("div_q", 4'd6, 16'd14);

        op1(OP_PASS, 4'd3, 4'd0, 4'd13, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            op1(OP_SHL1, 4'd13, 4'd0, 4'd13, 1'b1);
            if (k == 2 || k == 4 || k == 5 || k == 9 || k == 12)
                op1(OP_OR, 4'd1, 4'd13, 4'd1, 1'b1);
        end
        reg_is("r1_1234", 4'd1, 16'h1234);

        do_div(4'd1, 4'd0, 4'd9, e, l);
        chk("dbz_edges", e, 2);
        chk("dbz_flags", {28'h0, div_err, zero, paridad, mayor}, 32'b1001);
        chk("dbz_rem", {16'h0, remainder}, 32'h1234);
        reg_is("dbz_q", 4'd9, 16'hFFFF);

        op1(OP_ADD, 4'd3, 4'd3, 4'd10, 1'b1);
        chk("add_clears_err", {30'h0, done, div_err}, 32'b10);
        reg_is("r10_two", 4'd10, 16'h0002);

        op1(OP_ADD, 4'd3, 4'd3, 4'd2, 1'b0);
        chk("we0_flags", {30'h0, done, paridad}, 32'b11);
        reg_is("we0_nowrite", 4'd2, 16'h7FFF);

        // reset partway through a DIV, with a new op offered during reset
        @(negedge clk);
        bus.instr_op    = OP_DIV;
        bus.instr_ra    = 4'd12;
        bus.instr_rb    = 4'd7;
        bus.instr_rd    = 4'd11;
        bus.instr_we    = 1'b1;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst             = 1'b1;
        bus.instr_op    = OP_ADD;
        bus.instr_ra    = 4'd3;
        bus.instr_rb    = 4'd3;
        bus.instr_rd    = 4'd1;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", {30'h0, bus.instr_ready, done}, 32'b00);
        @(negedge clk);
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        #1;
        chk("post_rst_ready", {31'h0, bus.instr_ready}, 32'h1);
        reg_is("rst_r11", 4'd11, 16'h0000);
        reg_is("rst_r1", 4'd1, 16'h0000);
        spur = 0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (done) spur++;
        end
        chk("no_retire_after_rst", spur, 0);

        do_div(4'd0, 4'd0, 4'd1, e, l);
        chk("post_rst_div_edges", e, 2);
        reg_is("post_rst_div_q", 4'd1, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
